// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: performs loads/stores on a ready-handshaked data bus,
// formats load data and hands a registered single-cycle bundle to write-back.
module mem_access_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            in_ready,
    input  logic            mem_re,
    input  logic            mem_we,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] store_data,
    input  logic [1:0]      wb_sel_in,
    input  logic [XLEN-1:0] immediate_in,
    input  logic [XLEN-1:0] pc_next_in,
    input  logic [4:0]      rd_in,
    input  logic            reg_we_in,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            valid_out,
    output logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] immediate_out,
    output logic [XLEN-1:0] pc_next_out,
    output logic [1:0]      wb_sel_out,
    output logic [4:0]      rd_out,
    output logic            reg_we_out,
    output logic            mem_fault
);

    typedef enum logic {IDLE, BUS} state_t;

    state_t          state;
    logic            accept_c;
    logic            fault_c;
    logic [XLEN-1:0] st_wdata_c;
    logic [3:0]      st_wstrb_c;
    logic [XLEN-1:0] ld_data_c;
    logic [7:0]      ld_byte_c;
    logic [15:0]     ld_half_c;

    // Sideband and access info held while the bus transaction is outstanding
    logic [2:0]      ld_f3;
    logic [1:0]      ld_off;
    logic            ld_is_load;
    logic [XLEN-1:0] sb_alu;
    logic [XLEN-1:0] sb_imm;
    logic [XLEN-1:0] sb_pc;
    logic [1:0]      sb_wb_sel;
    logic [4:0]      sb_rd;
    logic            sb_reg_we;

    assign in_ready = (state == IDLE);
    assign accept_c = valid_in && in_ready;

    // Illegal size/sign encodings and misalignment
    always_comb begin
        fault_c = 1'b0;
        if (mem_re && mem_we) begin
            fault_c = 1'b1;
        end else if (mem_re || mem_we) begin
            case (funct3)
                3'b000:  fault_c = 1'b0;
                3'b001:  fault_c = alu_result_in[0];
                3'b010:  fault_c = (alu_result_in[1:0] != 2'b00);
                3'b100:  fault_c = mem_we;
                3'b101:  fault_c = mem_we | alu_result_in[0];
                default: fault_c = 1'b1;
            endcase
        end
    end

    always_comb begin
        st_wdata_c = store_data;
        st_wstrb_c = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                st_wdata_c = {4{store_data[7:0]}};
                st_wstrb_c = 4'b0001 << alu_result_in[1:0];
            end
            2'b01: begin
                st_wdata_c = {2{store_data[15:0]}};
                st_wstrb_c = 4'b0011 << alu_result_in[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off)
            2'd0:    ld_byte_c = dmem_rdata[7:0];
            2'd1:    ld_byte_c = dmem_rdata[15:8];
            2'd2:    ld_byte_c = dmem_rdata[23:16];
            default: ld_byte_c = dmem_rdata[31:24];
        endcase
        ld_half_c = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_data_c = {{(XLEN-8){ld_byte_c[7]}}, ld_byte_c};
            3'b001:  ld_data_c = {{(XLEN-16){ld_half_c[15]}}, ld_half_c};
            3'b100:  ld_data_c = {{(XLEN-8){1'b0}}, ld_byte_c};
            3'b101:  ld_data_c = {{(XLEN-16){1'b0}}, ld_half_c};
            default: ld_data_c = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            dmem_wstrb     <= 4'b0000;
            valid_out      <= 1'b0;
            mem_data       <= '0;
            alu_result_out <= '0;
            immediate_out  <= '0;
            pc_next_out    <= '0;
            wb_sel_out     <= 2'b00;
            rd_out         <= 5'd0;
            reg_we_out     <= 1'b0;
            mem_fault      <= 1'b0;
            ld_f3          <= 3'b000;
            ld_off         <= 2'b00;
            ld_is_load     <= 1'b0;
            sb_alu         <= '0;
            sb_imm         <= '0;
            sb_pc          <= '0;
            sb_wb_sel      <= 2'b00;
            sb_rd          <= 5'd0;
            sb_reg_we      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        if ((!mem_re && !mem_we) || fault_c) begin
                            // Completes in one cycle without touching the bus
                            valid_out      <= 1'b1;
                            mem_data       <= '0;
                            alu_result_out <= alu_result_in;
                            immediate_out  <= immediate_in;
                            pc_next_out    <= pc_next_in;
                            wb_sel_out     <= wb_sel_in;
                            rd_out         <= rd_in;
                            reg_we_out     <= reg_we_in && !fault_c;
                            mem_fault      <= fault_c;
                        end else begin
                            state      <= BUS;
                            dmem_req   <= 1'b1;
                            dmem_we    <= mem_we;
                            dmem_addr  <= {alu_result_in[XLEN-1:2], 2'b00};
                            dmem_wdata <= mem_we ? st_wdata_c : '0;
                            dmem_wstrb <= mem_we ? st_wstrb_c : 4'b0000;
                            ld_f3      <= funct3;
                            ld_off     <= alu_result_in[1:0];
                            ld_is_load <= mem_re;
                            sb_alu     <= alu_result_in;
                            sb_imm     <= immediate_in;
                            sb_pc      <= pc_next_in;
                            sb_wb_sel  <= wb_sel_in;
                            sb_rd      <= rd_in;
                            sb_reg_we  <= reg_we_in;
                        end
                    end
                end
                BUS: begin
                    if (dmem_ready) begin
                        state          <= IDLE;
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        dmem_wstrb     <= 4'b0000;
                        valid_out      <= 1'b1;
                        mem_data       <= ld_is_load ? ld_data_c : '0;
                        alu_result_out <= sb_alu;
                        immediate_out  <= sb_imm;
                        pc_next_out    <= sb_pc;
                        wb_sel_out     <= sb_wb_sel;
                        rd_out         <= sb_rd;
                        reg_we_out     <= sb_reg_we;
                        mem_fault      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, hand-written corner sequences
// and randomized operations checked against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, in_ready, mem_re, mem_we;
    logic [2:0]  funct3;
    logic [31:0] alu_result_in, store_data, immediate_in, pc_next_in;
    logic [1:0]  wb_sel_in;
    logic [4:0]  rd_in;
    logic        reg_we_in;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        valid_out, reg_we_out, mem_fault;
    logic [31:0] mem_data, alu_result_out, immediate_out, pc_next_out;
    logic [1:0]  wb_sel_out;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .in_ready(in_ready),
        .mem_re(mem_re), .mem_we(mem_we), .funct3(funct3),
        .alu_result_in(alu_result_in), .store_data(store_data),
        .wb_sel_in(wb_sel_in), .immediate_in(immediate_in), .pc_next_in(pc_next_in),
        .rd_in(rd_in), .reg_we_in(reg_we_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .valid_out(valid_out), .mem_data(mem_data), .alu_result_out(alu_result_out),
        .immediate_out(immediate_out), .pc_next_out(pc_next_out),
        .wb_sel_out(wb_sel_out), .rd_out(rd_out), .reg_we_out(reg_we_out),
        .mem_fault(mem_fault)
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          lat;
        logic        e_fault;
        logic [31:0] e_data;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic re, logic we, logic [2:0] f3, logic [31:0] addr,
                                logic [31:0] sd, logic [31:0] rdata, int lat, logic e_fault,
                                logic [31:0] e_data, logic [31:0] e_wdata, logic [3:0] e_wstrb);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.addr = addr; v.sd = sd; v.rdata = rdata;
        v.lat = lat; v.e_fault = e_fault; v.e_data = e_data; v.e_wdata = e_wdata;
        v.e_wstrb = e_wstrb;
        return v;
    endfunction

    // Reference model: access size in bytes, alignment by modulo, lanes by shifting/replication
    function automatic vec_t model(vec_t v);
        int unsigned size;
        int unsigned off;
        logic [31:0] tmp;
        logic        legal_ld, legal_st;
        size     = 1 << v.f3[1:0];
        off      = v.addr % 4;
        legal_ld = (v.f3 == 3'd0) || (v.f3 == 3'd1) || (v.f3 == 3'd2) ||
                   (v.f3 == 3'd4) || (v.f3 == 3'd5);
        legal_st = (v.f3 <= 3'd2);
        v.e_fault = (v.re && v.we) || (v.re && !legal_ld) || (v.we && !legal_st) ||
                    ((v.re || v.we) && (v.addr % size) != 0);
        v.e_data  = 32'h0;
        v.e_wdata = 32'h0;
        v.e_wstrb = 4'h0;
        if (v.re && !v.e_fault) begin
            tmp = v.rdata >> (8 * off);
            if (size == 1) begin
                tmp = tmp & 32'hFF;
                if (!v.f3[2] && tmp >= 32'h80) tmp = tmp - 32'h100;
            end else if (size == 2) begin
                tmp = tmp & 32'hFFFF;
                if (!v.f3[2] && tmp >= 32'h8000) tmp = tmp - 32'h10000;
            end
            v.e_data = tmp;
        end
        if (v.we && !v.e_fault) begin
            if (size == 1)      v.e_wdata = (v.sd & 32'hFF) * 32'h0101_0101;
            else if (size == 2) v.e_wdata = (v.sd & 32'hFFFF) * 32'h0001_0001;
            else                v.e_wdata = v.sd;
            v.e_wstrb = 4'(((1 << size) - 1) << off);
        end
        return v;
    endfunction

    task automatic idle_inputs();
        valid_in = 1'b0; mem_re = 1'b0; mem_we = 1'b0; funct3 = 3'd0;
        alu_result_in = 32'h0; store_data = 32'h0; immediate_in = 32'h0;
        pc_next_in = 32'h0; wb_sel_in = 2'd0; rd_in = 5'd0; reg_we_in = 1'b0;
    endtask

    task automatic run_op(input vec_t v);
        logic [31:0] imm, pc;
        logic [4:0]  rd;
        logic [1:0]  wb;
        logic        rwe, bus;
        imm = $urandom; pc = $urandom; rd = 5'($urandom); wb = 2'($urandom);
        rwe = 1'($urandom);
        bus = (v.re || v.we) && !v.e_fault;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        valid_in = 1'b1; mem_re = v.re; mem_we = v.we; funct3 = v.f3;
        alu_result_in = v.addr; store_data = v.sd; immediate_in = imm;
        pc_next_in = pc; wb_sel_in = wb; rd_in = rd; reg_we_in = rwe;
        @(negedge clk);
        idle_inputs();
        if (bus) begin
            for (int c = 1; c <= v.lat; c++) begin
                check("bus_req", 32'(dmem_req), 32'd1);
                check("bus_in_ready", 32'(in_ready), 32'd0);
                check("bus_valid_out", 32'(valid_out), 32'd0);
                check("bus_addr", dmem_addr, {v.addr[31:2], 2'b00});
                check("bus_we", 32'(dmem_we), 32'(v.we));
                check("bus_wstrb", 32'(dmem_wstrb), 32'(v.e_wstrb));
                if (v.we) check("bus_wdata", dmem_wdata, v.e_wdata);
                if (c == v.lat) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = v.rdata;
                end
                @(negedge clk);
            end
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
        end else begin
            check("no_bus_req", 32'(dmem_req), 32'd0);
        end
        check("valid_out", 32'(valid_out), 32'd1);
        check("mem_fault", 32'(mem_fault), 32'(v.e_fault));
        check("mem_data", mem_data, v.e_data);
        check("alu_result_out", alu_result_out, v.addr);
        check("immediate_out", immediate_out, imm);
        check("pc_next_out", pc_next_out, pc);
        check("wb_sel_out", 32'(wb_sel_out), 32'(wb));
        check("rd_out", 32'(rd_out), 32'(rd));
        check("reg_we_out", 32'(reg_we_out), 32'(rwe && !v.e_fault));
        @(negedge clk);
        check("valid_pulse", 32'(valid_out), 32'd0);
        check("mem_data_hold", mem_data, v.e_data);
    endtask

    vec_t tbl[13];
    vec_t rv;

    initial begin
        idle_inputs();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid_out", 32'(valid_out), 32'd0);
        check("rst_dmem_req", 32'(dmem_req), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mem_data", mem_data, 32'h0);
        check("rst_rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1;

        // Back-to-back non-memory bundles
        @(negedge clk);
        valid_in = 1'b1; alu_result_in = 32'h1234; rd_in = 5'd5; reg_we_in = 1'b1;
        @(negedge clk);
        check("b2b_valid0", 32'(valid_out), 32'd1);
        check("b2b_alu0", alu_result_out, 32'h1234);
        check("b2b_rd0", 32'(rd_out), 32'd5);
        check("b2b_rwe0", 32'(reg_we_out), 32'd1);
        check("b2b_req0", 32'(dmem_req), 32'd0);
        alu_result_in = 32'h5678; rd_in = 5'd7; reg_we_in = 1'b0;
        @(negedge clk);
        idle_inputs();
        check("b2b_valid1", 32'(valid_out), 32'd1);
        check("b2b_alu1", alu_result_out, 32'h5678);
        check("b2b_rd1", 32'(rd_out), 32'd7);
        check("b2b_req1", 32'(dmem_req), 32'd0);
        @(negedge clk);
        check("b2b_valid_drop", 32'(valid_out), 32'd0);

        //            re    we    f3    addr          sd            rdata        lat fault data          wdata         wstrb
        tbl[0]  = mk(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0,        32'h0,        1, 1'b0, 32'h0,        32'h0,        4'h0);
        tbl[1]  = mk(1'b1, 1'b0, 3'd0, 32'h0000_1003, 32'h0,        32'h80FF_0000, 3, 1'b0, 32'hFFFF_FF80, 32'h0,        4'h0);
        tbl[2]  = mk(1'b1, 1'b0, 3'd5, 32'h0000_2002, 32'h0,        32'h8001_1234, 1, 1'b0, 32'h0000_8001, 32'h0,        4'h0);
        tbl[3]  = mk(1'b0, 1'b1, 3'd0, 32'h0000_3001, 32'hAABB_CCDD, 32'h0,        2, 1'b0, 32'h0,        32'hDDDD_DDDD, 4'b0010);
        tbl[4]  = mk(1'b0, 1'b1, 3'd1, 32'h0000_3002, 32'hAABB_CCDD, 32'h0,        1, 1'b0, 32'h0,        32'hCCDD_CCDD, 4'b1100);
        tbl[5]  = mk(1'b1, 1'b0, 3'd2, 32'h0000_4002, 32'h0,        32'h0,        1, 1'b1, 32'h0,        32'h0,        4'h0);
        tbl[6]  = mk(1'b1, 1'b0, 3'd3, 32'h0000_4000, 32'h0,        32'h0,        1, 1'b1, 32'h0,        32'h0,        4'h0);
        tbl[7]  = mk(1'b0, 1'b1, 3'd2, 32'h0000_5000, 32'h1234_5678, 32'h0,        1, 1'b0, 32'h0,        32'h1234_5678, 4'b1111);
        tbl[8]  = mk(1'b1, 1'b0, 3'd1, 32'h0000_6002, 32'h0,        32'hF00D_0000, 2, 1'b0, 32'hFFFF_F00D, 32'h0,        4'h0);
        tbl[9]  = mk(1'b1, 1'b0, 3'd4, 32'h0000_7001, 32'h0,        32'h0000_A500, 4, 1'b0, 32'h0000_00A5, 32'h0,        4'h0);
        tbl[10] = mk(1'b1, 1'b1, 3'd0, 32'h0000_8000, 32'h0,        32'h0,        1, 1'b1, 32'h0,        32'h0,        4'h0);
        tbl[11] = mk(1'b0, 1'b1, 3'd4, 32'h0000_9000, 32'h0,        32'h0,        1, 1'b1, 32'h0,        32'h0,        4'h0);
        tbl[12] = mk(1'b0, 1'b1, 3'd1, 32'h0000_3001, 32'h0,        32'h0,        1, 1'b1, 32'h0,        32'h0,        4'h0);
        for (int i = 0; i < 13; i++) run_op(tbl[i]);

        // Reset during an outstanding load abandons it
        @(negedge clk);
        valid_in = 1'b1; mem_re = 1'b1; funct3 = 3'd2; alu_result_in = 32'h0000_A000;
        @(negedge clk);
        idle_inputs();
        check("rstbus_req1", 32'(dmem_req), 32'd1);
        @(negedge clk);
        check("rstbus_req2", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstbus_req_off", 32'(dmem_req), 32'd0);
        check("rstbus_valid", 32'(valid_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstbus_in_ready", 32'(in_ready), 32'd1);
        check("rstbus_valid2", 32'(valid_out), 32'd0);
        check("rstbus_req3", 32'(dmem_req), 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            int kind;
            kind = $urandom_range(0, 9);
            rv.re    = (kind >= 2 && kind <= 5) || kind == 9;
            rv.we    = (kind >= 6);
            rv.f3    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) rv.f3 = rv.we ? 3'($urandom_range(0, 2))
                                                         : 3'($urandom_range(0, 5));
            rv.addr  = $urandom;
            rv.sd    = $urandom;
            rv.rdata = $urandom;
            rv.lat   = $urandom_range(1, 4);
            rv = model(rv);
            run_op(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Multi-cycle memory-access stage sitting directly upstream of the write-back stage.
- Takes the executed instruction (ALU result as address, store data, load/store control) and performs the load or store on a ready-handshaked data-memory bus.
- Formats load data by size/sign and presents a registered, single-cycle-valid bundle (mem_data plus pass-through write-back sideband) to write-back.
- Stalls upstream while a bus transaction is outstanding.

Parameters:
- XLEN, 32, datapath and address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- valid_in  in  1  instruction present from execute
- in_ready  out  1  stage can accept this cycle
- mem_re  in  1  load
- mem_we  in  1  store
- funct3  in  3  access size/sign
- alu_result_in  in  32  effective address / ALU value
- store_data  in  32  rs2 value
- wb_sel_in  in  2  pass-through
- immediate_in  in  32  pass-through
- pc_next_in  in  32  pass-through
- rd_in  in  5  pass-through
- reg_we_in  in  1  pass-through
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte enables (0 on reads)
- dmem_ready  in  1  bus completion
- dmem_rdata  in  32  read word
- valid_out  out  1  bundle valid to write-back
- mem_data  out  32  formatted load data
- alu_result_out  out  32  registered
- immediate_out  out  32  registered
- pc_next_out  out  32  registered
- wb_sel_out  out  2  registered
- rd_out  out  5  registered
- reg_we_out  out  1  registered, gated
- mem_fault  out  1  misaligned or illegal access, qualified by valid_out

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous, active-low.
- Reset values: all registered outputs 0, state IDLE, dmem_req 0. Reset asserted in BUS abandons the transaction; dmem_req is 0 the cycle after the reset edge; no valid_out is produced.
- States: IDLE, BUS. in_ready = (state==IDLE).
- Accept: valid_in && in_ready at an edge. Sideband is captured then.
- Non-memory op (mem_re=mem_we=0): outputs registered at the accept edge, valid_out=1 for the next cycle, state stays IDLE. Throughput 1/cycle, latency 1.
- Fault check at accept:
  - mem_re && mem_we → fault.
  - Load funct3 not in {000,001,010,100,101} → fault.
  - Store funct3 not in {000,001,010} → fault.
  - Halfword with addr[0]=1 → fault.
  - Word with addr[1:0]≠0 → fault.
  - On fault: no bus request; next cycle valid_out=1, mem_fault=1, reg_we_out=0, mem_data=0; state stays IDLE.
- Legal memory op: IDLE→BUS at the accept edge. In BUS:
  - dmem_req=1 with dmem_addr={addr[31:2],2'b00}.
  - dmem_we, dmem_wdata, dmem_wstrb held stable until dmem_ready=1 is sampled.
  - On that edge: load data formatted into mem_data, valid_out=1 for the next cycle, state→IDLE.
  - Latency = 1 + number of BUS cycles. The earliest case is dmem_ready high in the first BUS cycle, giving valid_out 2 cycles after accept.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=sd, wstrb=4'b1111.
  - Stores return mem_data=0, with reg_we_out as supplied.
- Load extract: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes rdata.
- valid_out is a one-cycle pulse. With no new accept it returns to 0. The other outputs hold their last values.
- valid_in while in BUS is ignored (not captured). Upstream must hold it until in_ready.

Test Plan:
- Reset, then ADD-type bundle (mem_re=mem_we=0, alu_result_in=0x1234, rd_in=5, reg_we_in=1) → valid_out next cycle, alu_result_out=0x1234, rd_out=5, dmem_req never asserted; back-to-back bundles give valid_out on consecutive cycles.
- LB at 0x1003 with rdata=0x80FF_0000 and dmem_ready delayed 3 cycles → dmem_req high 3 cycles, dmem_addr=0x1000, in_ready low throughout, then mem_data=0xFFFF_FF80.
- LHU at 0x2002 with rdata=0x8001_xxxx and ready in the first BUS cycle → mem_data=0x0000_8001, valid_out 2 cycles after accept.
- SB at 0x3001 with store_data=0xAABB_CCDD → dmem_we=1, wdata=0xDDDD_DDDD, wstrb=0010; SH at 0x3002 → wdata=0xCCDD_CCDD, wstrb=1100.
- LW at 0x4002 → no dmem_req, valid_out with mem_fault=1 and reg_we_out=0; load funct3=011 → same fault response.
- Load issued, rst_n low in the second BUS cycle (ready low) → dmem_req=0 next cycle, valid_out stays 0, in_ready=1 after reset release.
